serial_demux_deser: RTL
=======================

Name: serial_demux_deser

Overview:
- 1-to-8 steering deserializer: the receive-side counterpart of the team's 8-to-1 select mux.
- The mux drives bit d[7-s] onto a serial line for s = 0..7. This block takes that serial stream back in and writes each bit to slot q[7-k] as its internal index k counts 0..7.
- After the 8th bit it presents the reassembled byte with a one-cycle valid strobe.
- Sits between a serial source (e.g. mux plus select counter) and parallel consumers.

Parameters:
- WIDTH, 8, word width in bits; number of slots per frame.
- CNT_W, 3, width of slot index; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin (or restart) a frame.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- sel  output  CNT_W  slot index the next accepted bit fills (same encoding as mux select s).
- q  output  WIDTH  last completed word.
- q_valid  output  1  one-cycle strobe: q just updated.
- busy  output  1  frame in progress.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - state=IDLE.
  - cnt=0, so sel=0.
  - shadow register=0, q=0.
  - q_valid=0, busy=0.
- State machine, registered: IDLE, COLLECT.
- IDLE:
  - busy=0, sel=0.
  - din_valid is ignored.
  - start=1 → COLLECT next cycle with cnt=0 and shadow cleared. Any din on the start cycle is discarded.
- COLLECT:
  - busy=1, sel=cnt.
  - start=1 (priority over din_valid): restart. cnt<=0, shadow<=0, that cycle's bit discarded, stay COLLECT. q and q_valid are unaffected.
  - din_valid=1 and start=0: shadow[WIDTH-1-cnt]<=din and cnt<=cnt+1.
  - din_valid=0: hold; gaps of any length are allowed.
  - Accepting the bit when cnt==WIDTH-1 completes the frame, on that same edge:
    - q<=shadow with the final bit merged in, i.e. q[0]=din.
    - q_valid<=1.
    - cnt<=0 (natural wrap 7→0).
    - state<=IDLE.
- Output timing:
  - Latency: q and q_valid are visible in the cycle after the edge that samples the 8th bit.
  - q_valid is high for exactly 1 cycle, then 0. It is never high for two consecutive cycles.
  - q holds its value until the next completed frame; an aborted or restarted frame never changes q.
- Back-to-back frames: in the q_valid cycle the state is IDLE, so start accepted in that cycle begins the next frame. Minimum frame period is WIDTH+1 cycles (1 start + 8 bits).
- Bit order is MSB first: the first bit lands in q[WIDTH-1], the last in q[0].
- Reset mid-frame: the partial frame is lost and all outputs return to reset values immediately. After rst_n deasserts, start is required before any bit is accepted.
- X-safety: din is only sampled when din_valid=1 in COLLECT. No output may depend on din otherwise.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → q=8'h00, q_valid=0, busy=0, sel=0 immediately, without waiting for a clock edge.
- Basic frame:
  - Stimulus: start, then din=1,0,1,0,0,1,0,1 with din_valid=1 for 8 consecutive cycles.
  - Response: sel steps 0..7; q=8'hA5 with q_valid=1 for exactly the cycle after the 8th bit; busy=0 in that cycle.
- Gapped input:
  - Stimulus: frame 8'h3C with din_valid deasserted for 3 cycles after bit 2 and 1 cycle after bit 5, with din toggling randomly during the gaps.
  - Response: q=8'h3C; completion is delayed by 4 cycles; sel holds during the gaps.
- Restart and abort:
  - Stimulus: after 5 bits of 8'hFF, assert start, then send 8'h12.
  - Response: q=8'h12; q_valid pulses once; q is unchanged (prior value) during the aborted frame. Repeat with rst_n pulsed after bit 4 → q=0, and no q_valid until a new full frame.
- Back-to-back:
  - Stimulus: assert start in the q_valid cycle of frame 8'h81, followed immediately by frame 8'h7E.
  - Response: two q_valid pulses exactly 9 cycles apart; q=8'h81 then 8'h7E.
- Loopback with the 8-to-1 mux:
  - Stimulus: drive mux s from this block's sel and mux y into din, with mux d = random 8-bit values over 256 frames.
  - Response: each q equals the mux d word, bit-exact.

Source files
------------

// File: rtl/serial_demux_deser_if.sv
// Bundle for the serial-to-parallel steering deserializer.
// Master drives the serial side; slave is the deserializer.
interface serial_demux_deser_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic             din;
  logic             din_valid;
  logic [CNT_W-1:0] sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;

  modport master (
    output start, din, din_valid,
    input  sel, q, q_valid, busy
  );

  modport slave (
    input  start, din, din_valid,
    output sel, q, q_valid, busy
  );
endinterface

// File: rtl/serial_demux_deser.sv
// 1-to-8 steering deserializer: collects an MSB-first serial frame into a
// shadow register and publishes the completed word with a one-cycle strobe.
module serial_demux_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_demux_deser_if.slave  bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             q_valid_r, q_valid_n;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shadow    <= shadow_n;
      q_r       <= q_n;
      q_valid_r <= q_valid_n;
    end
  end

  // Next-state logic: start has priority; the final bit is merged straight
  // into the published word so q is valid on the completing edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shadow_n  = shadow;
    q_n       = q_r;
    q_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n  = COLLECT;
          cnt_n    = '0;
          shadow_n = '0;
        end
      end
      COLLECT: begin
        if (bus.start) begin
          cnt_n    = '0;
          shadow_n = '0;
        end else if (bus.din_valid) begin
          shadow_n[LAST - cnt] = bus.din;
          if (cnt == LAST) begin
            q_n       = shadow_n;
            q_valid_n = 1'b1;
            cnt_n     = '0;
            state_n   = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs: sel is forced to 0 outside a frame.
  always_comb begin
    bus.sel     = (state == COLLECT) ? cnt : '0;
    bus.busy    = (state == COLLECT);
    bus.q       = q_r;
    bus.q_valid = q_valid_r;
  end

endmodule
